// File: rtl/i2c_addr_xlate_n.sv
// Virtual-to-physical I2C address translator: looks a request up in a small map,
// then runs one single-byte I2C transaction on the selected downstream channel.
module i2c_addr_xlate_n #(
   parameter  int NUM_CH    = 4,
   parameter  int MAP_DEPTH = 8,
   parameter  int CLK_DIV   = 125,
   localparam int IW = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [6:0]        req_vaddr_i,
   input  logic              req_rw_i,
   input  logic [7:0]        req_wdata_i,
   output logic              rsp_valid_o,
   output logic [7:0]        rsp_rdata_o,
   output logic              rsp_nack_o,
   output logic              rsp_miss_o,
   output logic              txn_done_o,
   input  logic              cfg_we_i,
   input  logic [IW-1:0]     cfg_idx_i,
   input  logic              cfg_en_i,
   input  logic [6:0]        cfg_vaddr_i,
   input  logic [6:0]        cfg_paddr_i,
   input  logic [CW-1:0]     cfg_ch_i,
   output logic [NUM_CH-1:0] scl_oe_o,
   output logic [NUM_CH-1:0] sda_oe_o,
   input  logic [NUM_CH-1:0] sda_in_i
);
   // state | meaning: IDLE wait req | LOOKUP map search | START/STOP bus conditions |
   // ADDR/DATA 8 bits | AACK/DACK ack bit | RESP one-cycle response
   localparam int            QW       = $clog2(CLK_DIV);
   localparam logic [QW-1:0] Q_RELOAD = QW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOOKUP, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [QW-1:0]   qcnt_q, qcnt_d;
   logic [1:0]      phase_q, phase_d;
   logic [2:0]      bit_q, bit_d;
   logic [6:0]      vaddr_q, vaddr_d, paddr_q, paddr_d;
   logic            rw_q, rw_d, nack_q, nack_d, alive_q;
   logic [7:0]      wdata_q, wdata_d, shift_q, shift_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            rnack_q, rnack_d, rmiss_q, rmiss_d;

   logic            map_en_q [MAP_DEPTH];
   logic [6:0]      map_v_q  [MAP_DEPTH];
   logic [6:0]      map_p_q  [MAP_DEPTH];
   logic [CW-1:0]   map_c_q  [MAP_DEPTH];

   logic            hit, tick, on_bus, sda_sel, scl_pull, sda_pull;
   logic [6:0]      hit_p;
   logic [CW-1:0]   hit_c;
   logic [7:0]      addr_byte;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < MAP_DEPTH; i++) begin
            map_en_q[i] <= 1'b0;
            map_v_q[i]  <= '0;
            map_p_q[i]  <= '0;
            map_c_q[i]  <= '0;
         end
      end else if (cfg_we_i) begin
         map_en_q[cfg_idx_i] <= cfg_en_i;
         map_v_q[cfg_idx_i]  <= cfg_vaddr_i;
         map_p_q[cfg_idx_i]  <= cfg_paddr_i;
         map_c_q[cfg_idx_i]  <= cfg_ch_i;
      end
   end

   // Scanning downward lets the lowest matching index overwrite the others.
   always_comb begin
      hit   = 1'b0;
      hit_p = '0;
      hit_c = '0;
      for (int i = MAP_DEPTH - 1; i >= 0; i--) begin
         if (map_en_q[i] && (map_v_q[i] == vaddr_q)) begin
            hit   = 1'b1;
            hit_p = map_p_q[i];
            hit_c = map_c_q[i];
         end
      end
   end

   always_comb begin
      sda_sel = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         if (ch_q == CW'(i)) sda_sel = sda_in_i[i];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         qcnt_q  <= Q_RELOAD;
         phase_q <= 2'd0;
         bit_q   <= 3'd0;
         vaddr_q <= '0;
         paddr_q <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
         shift_q <= '0;
         nack_q  <= 1'b0;
         ch_q    <= '0;
         rdata_q <= '0;
         rnack_q <= 1'b0;
         rmiss_q <= 1'b0;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         vaddr_q <= vaddr_d;
         paddr_q <= paddr_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
         shift_q <= shift_d;
         nack_q  <= nack_d;
         ch_q    <= ch_d;
         rdata_q <= rdata_d;
         rnack_q <= rnack_d;
         rmiss_q <= rmiss_d;
         alive_q <= 1'b1;
      end
   end

   assign tick   = (qcnt_q == '0);
   assign on_bus = (state_q != S_IDLE) && (state_q != S_LOOKUP) && (state_q != S_RESP);

   always_comb begin
      state_d = state_q;
      qcnt_d  = Q_RELOAD;
      phase_d = 2'd0;
      bit_d   = bit_q;
      vaddr_d = vaddr_q;
      paddr_d = paddr_q;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      shift_d = shift_q;
      nack_d  = nack_q;
      ch_d    = ch_q;
      rdata_d = rdata_q;
      rnack_d = rnack_q;
      rmiss_d = rmiss_q;
      if (on_bus) begin
         qcnt_d  = tick ? Q_RELOAD : qcnt_q - QW'(1);
         phase_d = tick ? phase_q + 2'd1 : phase_q;
      end
      case (state_q)
         S_IDLE: if (req_valid_i && req_ready_o) begin
            vaddr_d = req_vaddr_i;
            rw_d    = req_rw_i;
            wdata_d = req_wdata_i;
            shift_d = '0;
            nack_d  = 1'b0;
            state_d = S_LOOKUP;
         end
         S_LOOKUP: if (hit) begin
            paddr_d = hit_p;
            ch_d    = hit_c;
            state_d = S_START;
         end else begin
            state_d = S_RESP;
         end
         S_START: if (tick && phase_q == 2'd2) begin
            state_d = S_ADDR;
            phase_d = 2'd0;
            bit_d   = 3'd7;
         end
         S_ADDR: if (tick && phase_q == 2'd3) begin
            if (bit_q == 3'd0) state_d = S_AACK;
            else               bit_d   = bit_q - 3'd1;
         end
         S_AACK: begin
            if (tick && phase_q == 2'd2 && sda_sel) nack_d = 1'b1;
            if (tick && phase_q == 2'd3) begin
               state_d = nack_q ? S_STOP : S_DATA;
               bit_d   = 3'd7;
            end
         end
         S_DATA: begin
            if (tick && phase_q == 2'd2 && rw_q) shift_d = {shift_q[6:0], sda_sel};
            if (tick && phase_q == 2'd3) begin
               if (bit_q == 3'd0) state_d = S_DACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         S_DACK: begin
            if (tick && phase_q == 2'd2 && !rw_q && sda_sel) nack_d = 1'b1;
            if (tick && phase_q == 2'd3) state_d = S_STOP;
         end
         S_STOP: if (tick && phase_q == 2'd2) begin
            state_d = S_RESP;
            phase_d = 2'd0;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Response fields are captured on entry to RESP and then held.
      if (state_d == S_RESP && state_q != S_RESP) begin
         rdata_d = shift_q;
         rnack_d = nack_q;
         rmiss_d = (state_q == S_LOOKUP);
      end
   end

   assign addr_byte = {paddr_q, rw_q};

   always_comb begin
      scl_pull = 1'b0;
      sda_pull = 1'b0;
      case (state_q)
         S_START: begin
            scl_pull = (phase_q == 2'd2);
            sda_pull = (phase_q != 2'd0);
         end
         S_ADDR: begin
            scl_pull = (phase_q == 2'd0) || (phase_q == 2'd3);
            sda_pull = ~addr_byte[bit_q];
         end
         S_DATA: begin
            scl_pull = (phase_q == 2'd0) || (phase_q == 2'd3);
            sda_pull = ~rw_q & ~wdata_q[bit_q];
         end
         S_AACK, S_DACK: scl_pull = (phase_q == 2'd0) || (phase_q == 2'd3);
         S_STOP: begin
            scl_pull = (phase_q == 2'd0);
            sda_pull = (phase_q != 2'd2);
         end
         default: ;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         scl_oe_o[i] = scl_pull && (ch_q == CW'(i));
         sda_oe_o[i] = sda_pull && (ch_q == CW'(i));
      end
   end

   assign req_ready_o = alive_q && (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign txn_done_o  = (state_q == S_RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_nack_o  = rnack_q;
   assign rsp_miss_o  = rmiss_q;
endmodule
